// File: rtl/prog_mem_loader_pkg.sv
// Shared constants and loader state encoding for the 16x8 program memory.
// No logic here, so there is no latency and no backpressure.
package prog_mem_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    localparam logic [ADDR_W-1:0] IO_ADDR = 4'hF;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } ld_state_t;

endpackage

// File: rtl/prog_mem_loader_ram16x8.sv
// Single-port-write RAM: async read (0 cycles), write lands at the clk edge.
// No backpressure; the caller owns the write port arbitration.
module ram16x8
    import prog_mem_loader_pkg::ADDR_W;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory plus boot loader; CPU read 0 cycles, loader 1 byte/cycle, ld_ready high only in LOAD.
// Optional MEM_GPIO_EN maps address 15 to gpio_in/gpio_out for CPU accesses.
module prog_mem_loader #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [prog_mem_loader_pkg::ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0]                     cpu_data_w,
    input  logic                                  cpu_we,
    output logic [DATA_W-1:0]                     cpu_data_r,
    output logic                                  cpu_reset_n,
    input  logic                                  ld_valid,
    input  logic [DATA_W-1:0]                     ld_data,
    output logic                                  ld_ready,
    input  logic                                  ld_start,
    output logic                                  ld_done,
    input  logic [DATA_W-1:0]                     gpio_in,
    output logic [DATA_W-1:0]                     gpio_out
);

    import prog_mem_loader_pkg::*;

    ld_state_t         state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              io_hit;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            LOAD: begin
                // ld_start wins over a same-cycle beat, which is dropped
                if (ld_start) begin
                    cnt_nxt = '0;
                end else if (ld_valid) begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOAD;
            cnt         <= '0;
            cpu_reset_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cpu_reset_n <= (state_nxt == RUN);
        end
    end

    assign ld_ready = (state == LOAD);
    assign ld_done  = (state == RUN);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cpu_address;
        ram_wdata = cpu_data_w;
        if (state == LOAD) begin
            ram_we    = ld_valid && !ld_start;
            ram_addr  = cnt;
            ram_wdata = ld_data;
        end else begin
            ram_we    = cpu_we && !io_hit;
        end
    end

    ram16x8 #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_addr),
        .wdata  (ram_wdata),
        .raddr  (cpu_address),
        .rdata  (ram_rdata)
    );

`ifdef MEM_GPIO_EN
    assign io_hit = (cpu_address == IO_ADDR);

    // Only reset_n clears the port; a reload leaves the outputs alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_out <= '0;
        end else if (state == RUN && cpu_we && io_hit) begin
            gpio_out <= cpu_data_w;
        end
    end

    assign cpu_data_r = io_hit ? gpio_in : ram_rdata;
`else
    logic unused_gpio;

    assign io_hit      = 1'b0;
    assign gpio_out    = '0;
    assign cpu_data_r  = ram_rdata;
    assign unused_gpio = ^gpio_in;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: a memory/loader model checked every cycle plus literal spot checks.
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] cpu_address = '0;
    logic [7:0] cpu_data_w = '0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_data_r;
    logic       cpu_reset_n;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;
    logic       ld_start = 1'b0;
    logic       ld_done;
    logic [7:0] gpio_in = '0;
    logic [7:0] gpio_out;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MEM_GPIO_EN
    localparam bit GPIO = 1'b1;
`else
    localparam bit GPIO = 1'b0;
`endif

    prog_mem_loader #(.DEPTH(16), .DATA_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_address (cpu_address),
        .cpu_data_w  (cpu_data_w),
        .cpu_we      (cpu_we),
        .cpu_data_r  (cpu_data_r),
        .cpu_reset_n (cpu_reset_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_start    (ld_start),
        .ld_done     (ld_done),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "loading" flag, next load address, and the memory image as the CPU should see it
    bit       m_loading = 1'b1;
    int       m_next    = 0;
    bit [7:0] m_mem  [16];
    bit       m_known[16];
    bit [7:0] m_gpio = '0;
    bit       m_live = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_loading = 1'b1;
            m_next    = 0;
            m_gpio    = '0;
        end else if (m_loading) begin
            if (ld_start) begin
                m_next = 0;
            end else if (ld_valid) begin
                m_mem[m_next]   = ld_data;
                m_known[m_next] = 1'b1;
                m_next          = (m_next + 1) % 16;
                if (m_next == 0) m_loading = 1'b0;
            end
        end else begin
            if (cpu_we) begin
                if (GPIO && cpu_address == 4'hF) m_gpio = cpu_data_w;
                else begin
                    m_mem[cpu_address]   = cpu_data_w;
                    m_known[cpu_address] = 1'b1;
                end
            end
            if (ld_start) begin
                m_loading = 1'b1;
                m_next    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("ld_ready",    {7'b0, ld_ready},    {7'b0, m_loading});
            check("ld_done",     {7'b0, ld_done},     {7'b0, !m_loading});
            check("cpu_reset_n", {7'b0, cpu_reset_n}, {7'b0, reset_n && !m_loading});
            check("gpio_out",    gpio_out,            m_gpio);
            if (GPIO && cpu_address == 4'hF)
                check("cpu_data_r_io", cpu_data_r, gpio_in);
            else if (m_known[cpu_address])
                check("cpu_data_r", cpu_data_r, m_mem[cpu_address]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_data  = b;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        cpu_address = a;
        #1;
        check(name, cpu_data_r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        m_live  = 1'b1;
        #1;
        check("reset ld_ready",    {7'b0, ld_ready},    8'h01);
        check("reset cpu_reset_n", {7'b0, cpu_reset_n}, 8'h00);
        check("reset ld_done",     {7'b0, ld_done},     8'h00);
        check("reset gpio_out",    gpio_out,            8'h00);

        // Boot load 0x10..0x1F back-to-back
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h10 + 8'(i);
            if (i == 15) begin
                #1;
                check("beat16 ld_ready",    {7'b0, ld_ready},    8'h01);
                check("beat16 cpu_reset_n", {7'b0, cpu_reset_n}, 8'h00);
            end
            tick();
        end
        ld_valid = 1'b0;
        #1;
        check("cycle17 ld_ready",    {7'b0, ld_ready},    8'h00);
        check("cycle17 cpu_reset_n", {7'b0, cpu_reset_n}, 8'h01);
        read_check("boot addr3", 4'd3, 8'h13);

        // Store to address 5: old contents (0x15 from the boot stream) during the write cycle
        cpu_address = 4'd5;
        cpu_data_w  = 8'h07;
        cpu_we      = 1'b1;
        #1;
        check("store old", cpu_data_r, 8'h15);
        tick();
        cpu_we = 1'b0;
        #1;
        check("store new", cpu_data_r, 8'h07);

        // Reload with ld_valid toggling every other cycle
        pulse_start();
        #1;
        check("start cpu_reset_n", {7'b0, cpu_reset_n}, 8'h00);
        check("start ld_ready",    {7'b0, ld_ready},    8'h01);
        for (int i = 0; i < 32; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = 8'h40 + 8'(i / 2);
            tick();
        end
        ld_valid = 1'b0;
        #1;
        check("gap load done", {7'b0, ld_done}, 8'h01);
        for (int a = 0; a < 16; a++) begin
            read_check("gap load", 4'(a), 8'h40 + 8'(a));
        end

        // Collision: ld_start alongside a beat discards that beat
        pulse_start();
        for (int i = 0; i < 4; i++) beat(8'h50 + 8'(i));
        ld_start = 1'b1;
        beat(8'hEE);
        ld_start = 1'b0;
        for (int i = 0; i < 16; i++) beat(8'h60 + 8'(i));
        #1;
        check("collision done", {7'b0, ld_done}, 8'h01);
        read_check("collision addr0", 4'd0, 8'h60);
        read_check("collision addr4", 4'd4, 8'h64);

        // Async reset after 7 beats, then a fresh full load
        pulse_start();
        for (int i = 0; i < 7; i++) beat(8'h70 + 8'(i));
        #1;
        reset_n = 1'b0;
        #1;
        check("arst cpu_reset_n", {7'b0, cpu_reset_n}, 8'h00);
        check("arst ld_ready",    {7'b0, ld_ready},    8'h01);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) beat(8'h10 + 8'(i));
        #1;
        check("reload done", {7'b0, ld_done}, 8'h01);
        read_check("reload addr0", 4'd0, 8'h10);
        read_check("reload addr6", 4'd6, 8'h16);

        // Address 15: IO port with the option, plain RAM without
        gpio_in     = 8'hC3;
        cpu_address = 4'hF;
        cpu_data_w  = 8'h0A;
        cpu_we      = 1'b1;
        tick();
        cpu_we = 1'b0;
        #1;
        check("io gpio_out", gpio_out, GPIO ? 8'h0A : 8'h00);
        check("io read15",   cpu_data_r, GPIO ? 8'hC3 : 8'h0A);

        // gpio_out survives a reload request
        pulse_start();
        #1;
        check("io after start", gpio_out, GPIO ? 8'h0A : 8'h00);
        for (int i = 0; i < 16; i++) beat(8'h10 + 8'(i));
        repeat (3) tick();

        m_live = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
